// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared FSM state encoding, reset defaults and the misalignment mask for inst_fetch
package inst_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
    localparam logic [31:0] NOP_CMD_DEF   = 32'h0000_0013;
    localparam logic [31:0] MISALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetcher presenting one instruction at a time to the core
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_*      instruction-memory request channel (valid/ready, address)
//   resp_*     instruction-memory response (valid, data, error)
//   cmd/pc     presented instruction and its address, cmd_valid/cmd_ready handshake
//   dnpc       next pc from the core, taken when the instruction retires
//   fault      sticky fetch fault, left only by reset
//   instret    retired-instruction counter, wraps silently
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_CMD  = NOP_CMD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        resp_err,
    output logic [31:0] cmd,
    output logic [31:0] pc,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [31:0] dnpc,
    output logic        fault,
    output logic [31:0] instret
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_cmd;
    logic [31:0] r_instret;
    logic        w_retire;
    logic        w_misalign;
    logic        w_load;

    assign w_retire   = (r_state == S_HOLD) && cmd_ready;
    assign w_misalign = |(dnpc & MISALIGN_MASK);
    assign w_load     = (r_state == S_WAIT) && resp_valid && !resp_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_REQ;
            S_REQ:   w_next = req_ready ? S_WAIT : S_REQ;
            S_WAIT:  w_next = resp_valid ? (resp_err ? S_FAULT : S_HOLD) : S_WAIT;
            S_HOLD:  w_next = cmd_ready ? (w_misalign ? S_FAULT : S_REQ) : S_HOLD;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_cmd      <= NOP_CMD;
            r_instret  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_cmd <= resp_data;
            if (w_retire) begin
                r_fetch_pc <= dnpc;
                r_instret  <= r_instret + 32'd1;
            end
        end
    end

    // cmd_valid follows HOLD directly, so FAULT and every other state present the NOP
    assign cmd_valid = (r_state == S_HOLD);
    assign cmd       = cmd_valid ? r_cmd : NOP_CMD;
    assign req_valid = (r_state == S_REQ);
    assign req_addr  = r_fetch_pc;
    assign pc        = r_fetch_pc;
    assign fault     = (r_state == S_FAULT);
    assign instret   = r_instret;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] cmd;
    logic [31:0] pc;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] dnpc;
    logic        fault;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .cmd        (cmd),
        .pc         (pc),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .dnpc       (dnpc),
        .fault      (fault),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        resp_err = 1'b0; cmd_ready = 1'b0; dnpc = '0;
        tick(); tick();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_cmd", cmd, NOP);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_pc", pc, RST_PC);
        rst = 1'b1;
        tick();
        chk("req_valid_first", {31'd0, req_valid}, 32'd1);
        chk("req_addr_first", req_addr, RST_PC);
        // stall with req_ready low; stray response and retire must be ignored in REQ
        resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF; cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req_valid", {31'd0, req_valid}, 32'd1);
            chk("stall_req_addr", req_addr, RST_PC);
            chk("stall_cmd", cmd, NOP);
        end
        chk("stall_instret", instret, 32'd0);
        resp_valid = 1'b0; cmd_ready = 1'b0; req_ready = 1'b1;
        tick();
        chk("accept_req_valid", {31'd0, req_valid}, 32'd0);
        req_ready = 1'b0; cmd_ready = 1'b1;
        tick();
        chk("wait_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("wait_ready_ignored", instret, 32'd0);
        cmd_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0010_0093;
        tick();
        resp_valid = 1'b0; resp_data = 32'h1111_1111;
        chk("hold_cmd", cmd, 32'h0010_0093);
        chk("hold_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        chk("hold_pc", pc, RST_PC);
        tick();
        chk("hold_cmd_stable", cmd, 32'h0010_0093);
        chk("hold_valid_stable", {31'd0, cmd_valid}, 32'd1);
        cmd_ready = 1'b1; dnpc = 32'h8000_0010;
        tick();
        cmd_ready = 1'b0;
        chk("retire_instret", instret, 32'd1);
        chk("retire_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("retire_cmd", cmd, NOP);
        chk("retire_req_valid", {31'd0, req_valid}, 32'd1);
        chk("retire_req_addr", req_addr, 32'h8000_0010);
        chk("retire_pc", pc, 32'h8000_0010);
        // access error in WAIT
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; resp_valid = 1'b1; resp_err = 1'b1;
        tick();
        resp_valid = 1'b0; resp_err = 1'b0;
        chk("err_fault", {31'd0, fault}, 32'd1);
        chk("err_req_valid", {31'd0, req_valid}, 32'd0);
        chk("err_cmd", cmd, NOP);
        req_ready = 1'b1; cmd_ready = 1'b1;
        tick();
        req_ready = 1'b0; cmd_ready = 1'b0;
        chk("err_sticky", {31'd0, fault}, 32'd1);
        chk("err_instret", instret, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_fault", {31'd0, fault}, 32'd0);
        chk("async_rst_pc", pc, RST_PC);
        chk("async_rst_instret", instret, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        // reset during WAIT, then a late response before the new request is accepted
        rst = 1'b0;
        tick();
        rst = 1'b1; resp_valid = 1'b1; resp_data = 32'hCAFE_F00D;
        tick();
        tick();
        resp_valid = 1'b0;
        chk("stale_cmd", cmd, NOP);
        chk("stale_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("stale_req_valid", {31'd0, req_valid}, 32'd1);
        chk("stale_req_addr", req_addr, RST_PC);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        resp_valid = 1'b1; resp_data = 32'h0000_0513;
        tick();
        resp_valid = 1'b0;
        chk("fetch2_cmd", cmd, 32'h0000_0513);
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        chk("forced_instret", instret, 32'hFFFF_FFFF);
        cmd_ready = 1'b1; dnpc = 32'h8000_0006;
        tick();
        cmd_ready = 1'b0;
        chk("wrap_instret", instret, 32'd0);
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        chk("misalign_cmd", cmd, NOP);
        req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("misalign_req_valid", {31'd0, req_valid}, 32'd0);
        end
        req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("refault_rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b1;
        tick();
        chk("restart_req_valid", {31'd0, req_valid}, 32'd1);
        chk("restart_req_addr", req_addr, RST_PC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
